// File: rtl/pmem_types.sv
// Shared types and constants for the physical-memory burst responder.
// A line is PMEM_BEATS beats of 64 bits, addressed by byte offset bits [4:0].
package pmem_types;

  localparam int PMEM_BEATS    = 4;
  localparam int PMEM_OFFSET_W = 5;
  localparam int PMEM_BEAT_W   = 64;

  typedef logic [PMEM_BEAT_W-1:0] pmem_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST,
    ST_DONE
  } pmem_state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } pmem_op_e;

endpackage

// File: rtl/pmem_line_array.sv
// Single-port synchronous line store: DEPTH_LINES lines of four 64-bit beats.
// Read data appears one cycle after the address is presented.
module pmem_line_array
  import pmem_types::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  index,
  input  logic [1:0]        beat,
  input  logic              we,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata
);

  localparam int WORDS = DEPTH_LINES * PMEM_BEATS;

  pmem_beat_t         mem_q [WORDS];
  pmem_beat_t         rdata_q;
  logic [IDX_W+1:0]   addr_d;

  always_comb begin
    addr_d = {index, beat};
  end

  // NOTE: the storage array has no reset branch; clearing it would need a
  // per-word reset network and would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr_d] <= wdata;
    end
    rdata_q <= mem_q[addr_d];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pmem_burst_responder.sv
// Memory-side responder for the line burst interface: one request in, four
// 64-bit beats out after LATENCY idle cycles, with sticky protocol checking.
module pmem_burst_responder
  import pmem_types::*;
#(
  parameter int LATENCY     = 4,
  parameter int DEPTH_LINES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  logic [63:0] pmem_wdata,
  output logic        pmem_resp,
  output logic [63:0] pmem_rdata,
  output logic        proto_err
);

  localparam int IDX_W = $clog2(DEPTH_LINES);

  pmem_state_e       state_q, state_d;
  pmem_op_e          op_q, op_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [7:0]        lat_cnt_q, lat_cnt_d;
  logic [1:0]        beat_q, beat_d;
  logic              resp_q, resp_d;
  logic              proto_err_q, proto_err_d;

  logic              req_ok;
  logic              ram_we;
  logic [1:0]        ram_beat;
  logic [63:0]       ram_rdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{pmem_address[31:PMEM_OFFSET_W+IDX_W],
                              pmem_address[PMEM_OFFSET_W-1:0]};

  // The latched request must stay asserted alone for the whole transaction.
  always_comb begin
    req_ok = (op_q == OP_WRITE) ? (pmem_write && !pmem_read)
                                : (pmem_read && !pmem_write);
  end

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    index_d     = index_q;
    lat_cnt_d   = lat_cnt_q;
    beat_d      = beat_q;
    proto_err_d = proto_err_q;
    case (state_q)
      ST_IDLE: begin
        if (pmem_read && pmem_write) begin
          proto_err_d = 1'b1;
        end else if (pmem_read || pmem_write) begin
          state_d   = ST_WAIT;
          op_d      = pmem_write ? OP_WRITE : OP_READ;
          index_d   = pmem_address[PMEM_OFFSET_W +: IDX_W];
          lat_cnt_d = 8'(LATENCY);
          beat_d    = '0;
        end
      end
      ST_WAIT: begin
        if (!req_ok) begin
          state_d     = ST_IDLE;
          proto_err_d = 1'b1;
        end else if (lat_cnt_q == 8'd1) begin
          state_d   = ST_BURST;
          lat_cnt_d = '0;
          beat_d    = '0;
        end else begin
          lat_cnt_d = lat_cnt_q - 8'd1;
        end
      end
      ST_BURST: begin
        if (!req_ok) begin
          state_d     = ST_IDLE;
          proto_err_d = 1'b1;
        end else begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'(PMEM_BEATS - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    resp_d = (state_d == ST_BURST);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      index_q     <= '0;
      lat_cnt_q   <= '0;
      beat_q      <= '0;
      resp_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      index_q     <= index_d;
      lat_cnt_q   <= lat_cnt_d;
      beat_q      <= beat_d;
      resp_q      <= resp_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Reads prefetch one beat ahead to hide the RAM's read latency; writes
  // address the beat currently on the bus.
  always_comb begin
    if (op_q == OP_WRITE) begin
      ram_beat = beat_q;
    end else if (state_q == ST_BURST) begin
      ram_beat = beat_q + 2'd1;
    end else begin
      ram_beat = '0;
    end
    ram_we = rst && (state_q == ST_BURST) && (op_q == OP_WRITE) && req_ok;
  end

  pmem_line_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_line_array (
    .clk   (clk),
    .index (index_q),
    .beat  (ram_beat),
    .we    (ram_we),
    .wdata (pmem_wdata),
    .rdata (ram_rdata)
  );

  assign pmem_resp  = resp_q;
  assign pmem_rdata = resp_q ? ram_rdata : '0;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed bench for pmem_burst_responder: three instances at LATENCY 4, 1
// and 255, each with its own request signals and a shared address/wdata bus.
module tb_pmem_burst_responder;
  import pmem_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd [3];
  logic        wr [3];
  logic [31:0] addr_i = '0;
  logic [63:0] wdata_i = '0;
  logic        resp_o [3];
  logic [63:0] rdata_o [3];
  logic        perr_o [3];

  logic [63:0] beats [4];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  pmem_burst_responder #(.LATENCY(4), .DEPTH_LINES(256)) u_dut0 (
    .clk(clk), .rst(rst), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr_i), .pmem_wdata(wdata_i),
    .pmem_resp(resp_o[0]), .pmem_rdata(rdata_o[0]), .proto_err(perr_o[0]));

  pmem_burst_responder #(.LATENCY(1), .DEPTH_LINES(256)) u_dut1 (
    .clk(clk), .rst(rst), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr_i), .pmem_wdata(wdata_i),
    .pmem_resp(resp_o[1]), .pmem_rdata(rdata_o[1]), .proto_err(perr_o[1]));

  pmem_burst_responder #(.LATENCY(255), .DEPTH_LINES(256)) u_dut2 (
    .clk(clk), .rst(rst), .pmem_read(rd[2]), .pmem_write(wr[2]),
    .pmem_address(addr_i), .pmem_wdata(wdata_i),
    .pmem_resp(resp_o[2]), .pmem_rdata(rdata_o[2]), .proto_err(perr_o[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beats(input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3);
    beats[0] = b0;
    beats[1] = b1;
    beats[2] = b2;
    beats[3] = b3;
  endtask

  // Starts a request in the next cycle (cycle 0), holds it until the cycle
  // after the last beat, and checks resp timing and read data against beats[].
  task automatic do_burst(input int sel, input logic is_write,
                          input logic [31:0] addr, input int exp_first,
                          input string name);
    int first = -1;
    int n = 0;
    int done = -1;
    tick();
    addr_i  = addr;
    rd[sel] = !is_write;
    wr[sel] = is_write;
    wdata_i = '0;
    for (int c = 1; c <= 300 && done < 0; c++) begin
      tick();
      if (resp_o[sel]) begin
        if (first < 0) first = c;
        if (n < 4) begin
          if (is_write) begin
            wdata_i = beats[n];
          end else begin
            checks++;
            if (rdata_o[sel] !== beats[n]) begin
              errors++;
              $display("FAIL %s beat%0d: got %h expected %h", name, n, rdata_o[sel], beats[n]);
            end
          end
        end
        n++;
      end else if (first >= 0) begin
        done = c;
        rd[sel] = 1'b0;
        wr[sel] = 1'b0;
        checks++;
        if (rdata_o[sel] !== 64'h0) begin
          errors++;
          $display("FAIL %s idle_rdata: got %h expected 0", name, rdata_o[sel]);
        end
      end
    end
    rd[sel] = 1'b0;
    wr[sel] = 1'b0;
    checks++;
    if (first !== exp_first) begin
      errors++;
      $display("FAIL %s first_resp_cycle: got %0d expected %0d", name, first, exp_first);
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL %s resp_count: got %0d expected 4", name, n);
    end
    checks++;
    if (done !== exp_first + 4) begin
      errors++;
      $display("FAIL %s resp_low_cycle: got %0d expected %0d", name, done, exp_first + 4);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (resp_o[i] !== 1'b0 || rdata_o[i] !== 64'h0 || perr_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got resp=%b rdata=%h err=%b expected 0/0/0",
                 i, resp_o[i], rdata_o[i], perr_o[i]);
      end
    end
    checks++;
    if (u_dut0.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected IDLE", u_dut0.state_q);
    end
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    set_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    do_burst(0, 1'b1, 32'h0000_0040, 5, "wr_line2");
    do_burst(0, 1'b0, 32'h0000_0055, 5, "rd_line2");
  endtask

  task automatic test_wrap();
    set_beats(64'hA1A1_0000_0000_0001, 64'hA2A2_0000_0000_0002,
              64'hA3A3_0000_0000_0003, 64'hA4A4_0000_0000_0004);
    do_burst(0, 1'b1, 32'h0000_2000, 5, "wr_wrap");
    do_burst(0, 1'b0, 32'h0000_0000, 5, "rd_wrap");
  endtask

  task automatic test_latency();
    set_beats(64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
              64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404);
    do_burst(1, 1'b1, 32'h0000_0060, 2, "lat1_wr");
    do_burst(1, 1'b0, 32'h0000_0060, 2, "lat1_rd_b2b");
    set_beats(64'hDEAD_BEEF_0000_0000, 64'h0000_0000_CAFE_F00D,
              64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
    do_burst(2, 1'b1, 32'h0000_00A0, 256, "lat255_wr");
    do_burst(2, 1'b0, 32'h0000_00A0, 256, "lat255_rd");
  endtask

  task automatic test_both_high();
    logic saw_resp = 1'b0;
    tick();
    addr_i = 32'h0000_0040;
    rd[0] = 1'b1;
    wr[0] = 1'b1;
    tick();
    checks++;
    if (perr_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL both_high_err: got %b expected 1", perr_o[0]);
    end
    for (int c = 0; c < 10; c++) begin
      if (resp_o[0] !== 1'b0) saw_resp = 1'b1;
      tick();
    end
    checks++;
    if (saw_resp !== 1'b0 || u_dut0.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL both_high_no_resp: got resp_seen=%b state=%0d expected 0/IDLE",
               saw_resp, u_dut0.state_q);
    end
    rd[0] = 1'b0;
    wr[0] = 1'b0;
    set_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    do_burst(0, 1'b0, 32'h0000_0040, 5, "rd_after_both");
    checks++;
    if (perr_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL both_high_sticky: got %b expected 1", perr_o[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    tick();
    addr_i = 32'h0000_0040;
    rd[0] = 1'b1;
    for (int c = 0; c < 20 && n < 3; c++) begin
      tick();
      if (resp_o[0]) n++;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL rst_mid_reach_beat2: got %0d beats expected 3", n);
    end
    rst = 1'b0;
    tick();
    rd[0] = 1'b0;
    checks++;
    if (resp_o[0] !== 1'b0 || rdata_o[0] !== 64'h0 || perr_o[0] !== 1'b0 ||
        u_dut0.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_mid_outputs: got resp=%b rdata=%h err=%b state=%0d expected 0/0/0/IDLE",
               resp_o[0], rdata_o[0], perr_o[0], u_dut0.state_q);
    end
    rst = 1'b1;
    do_burst(0, 1'b0, 32'h0000_0040, 5, "rd_after_rst");
  endtask

  task automatic test_drop_wait();
    logic saw_resp = 1'b0;
    tick();
    checks++;
    if (perr_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL drop_pre_err: got %b expected 0", perr_o[0]);
    end
    addr_i = 32'h0000_0000;
    rd[0] = 1'b1;
    tick();
    tick();
    rd[0] = 1'b0;
    tick();
    checks++;
    if (perr_o[0] !== 1'b1 || u_dut0.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL drop_wait_abort: got err=%b state=%0d expected 1/IDLE",
               perr_o[0], u_dut0.state_q);
    end
    for (int c = 0; c < 8; c++) begin
      if (resp_o[0] !== 1'b0) saw_resp = 1'b1;
      tick();
    end
    checks++;
    if (saw_resp !== 1'b0) begin
      errors++;
      $display("FAIL drop_wait_no_resp: got resp_seen=%b expected 0", saw_resp);
    end
    set_beats(64'hA1A1_0000_0000_0001, 64'hA2A2_0000_0000_0002,
              64'hA3A3_0000_0000_0003, 64'hA4A4_0000_0000_0004);
    do_burst(0, 1'b0, 32'h0000_0000, 5, "rd_after_drop");
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0;
      wr[i] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_wrap();
    test_latency();
    test_both_high();
    test_reset_mid_burst();
    test_drop_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pmem_burst_responder.md
# pmem_burst_responder

Physical-memory-side responder for the core's CP2 burst interface: accepts one line-sized read or write request from the cache hierarchy and serves it as four 64-bit beats after a programmable access latency. It sits opposite the core's `pmem_*` ports in the testbench and FPGA top, backed by an internal line array. It also detects initiator protocol violations.

## Interface
- `LATENCY`, 4: idle cycles between request acceptance and the first beat; legal range 1–255.
- `DEPTH_LINES`, 256: number of 32-byte lines stored; power of two.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `pmem_read`  in  1  line read request; held by the initiator until the burst ends.
- `pmem_write`  in  1  line write request; held by the initiator until the burst ends.
- `pmem_address`  in  32  byte address; bits [4:0] are ignored; must be stable while a request is held.
- `pmem_wdata`  in  64  write beat; the initiator advances it after each `pmem_resp` beat.
- `pmem_resp`  out  1  beat strobe; high for exactly 4 consecutive cycles per burst.
- `pmem_rdata`  out  64  read beat; valid only while `pmem_resp` is high; 0 otherwise.
- `proto_err`  out  1  sticky protocol-violation flag; cleared only by reset.

## Operation
- FSM states:
  - IDLE: waits for a request.
  - WAIT: latency countdown.
  - BURST: beats 0–3.
  - DONE: one recovery cycle.
- IDLE → WAIT when exactly one of `pmem_read` and `pmem_write` is high.
  - Latches op and line index = `pmem_address[5 +: log2(DEPTH_LINES)]`. Upper address bits are ignored, so addresses wrap modulo the array.
  - Loads the latency counter with `LATENCY`.
- WAIT: the counter decrements each cycle. On reaching 1 the FSM moves to BURST with beat = 0.
- BURST:
  - `pmem_resp` = 1 and beat increments each cycle; after beat 3 the FSM moves to DONE.
  - Read: `pmem_rdata` = line[beat]. Beat 0 holds bytes 7:0 of the line, beat 3 holds bytes 31:24.
  - Write: line[beat] <= `pmem_wdata` at the edge that ends each BURST cycle.
- DONE: `pmem_resp` = 0; the FSM returns to IDLE unconditionally. This gives the initiator one cycle to drop its request, so back-to-back requests are accepted no earlier than the cycle after DONE.
- Protocol errors (`proto_err` <= 1 in each case):
  - `pmem_read` and `pmem_write` both high in IDLE: the request is ignored and the FSM stays in IDLE.
  - The latched request is deasserted, or the opposite op is asserted, during WAIT or BURST: the burst aborts and the FSM goes to IDLE. Write beats already committed remain.
  - An address change mid-request is not checked; the latched index is used.
- Reset (`rst` = 0 at an edge), including mid-burst:
  - State goes to IDLE; `pmem_resp` = 0, `pmem_rdata` = 0, `proto_err` = 0; counters are cleared.
  - Array contents are not reset.

## Timing
- Request first high in cycle 0, with the FSM in IDLE: `pmem_resp` is high in cycles `LATENCY`+1 through `LATENCY`+4.
- Minimum request-to-request spacing is `LATENCY`+6 cycles.
- `pmem_resp` and `pmem_rdata` come from the FSM and array outputs. They are registered-state-derived with no combinational path from inputs.
- The array read is synchronous: the read address for beat n+1 is presented during beat n, and for beat 0 during the last WAIT cycle. This keeps rdata aligned with resp.
- With `LATENCY` = 1, WAIT lasts one cycle.

## Structure
- Shared package `pmem_types`:
  - `PMEM_BEATS` = 4
  - `PMEM_OFFSET_W` = 5
  - `pmem_beat_t` (64-bit)
  - FSM state enum `pmem_state_e`
- Sub-module `pmem_line_array`: single-port synchronous RAM, `DEPTH_LINES` × 4 words of 64 bits. Inputs are index, beat, we, wdata; output is rdata with one-cycle read latency.
- The top contains the FSM, latency counter, beat counter and error logic.

## Test plan
- **Reset mid-burst:**
  - Stimulus: read accepted; `rst` low during beat 2.
  - Required: `pmem_resp`, `pmem_rdata` and `proto_err` are 0 next cycle and the FSM is in IDLE.
  - Required: a new read then returns the unmodified array contents.
- **Write then read, same line:**
  - Stimulus: write to 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44; then read from 0x0000_0055.
  - Required: resp in cycles 5–8 for each burst at `LATENCY` = 4; the read returns the same four beats in order.
- **Wrap-around:**
  - Stimulus: `DEPTH_LINES` = 256; write to 0x0000_2000 (line 256 → 0); then read from 0x0000_0000.
  - Required: the written data is returned.
- **Latency extremes:**
  - Stimulus: `LATENCY` = 1 and `LATENCY` = 255, with the request held.
  - Required: first resp in cycle 2 and cycle 256 respectively; exactly 4 resp cycles; then one low cycle before the next resp window can open.
- **Simultaneous read and write in IDLE:**
  - Stimulus: `pmem_read` and `pmem_write` both high in IDLE.
  - Required: `proto_err` = 1 the next cycle and no resp ever occurs; after both drop and a legal read follows, `proto_err` stays 1.
- **Request dropped mid-WAIT:**
  - Stimulus: read held, then dropped during WAIT.
  - Required: no resp, `proto_err` = 1, the FSM is in IDLE the next cycle, and the next legal request is served normally.
